// File: rtl/wb_stage.sv
// Writeback stage: one pipeline register, load align/extend, result select.
// Ports: clk, rst (sync, active-high), stall, flush, in_* capture fields;
//   we3/wa3/wd3 register-file write port; fwd_* forwarding copy of it.
// Option: define WB_RETIRE_CNT_EN to add the 32-bit retire_cnt output.
module wb_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        in_valid,
  input  logic        in_regwrite,
  input  logic [4:0]  in_wa,
  input  logic [1:0]  in_resultsrc,
  input  logic [31:0] in_alu,
  input  logic [31:0] in_rdata,
  input  logic [31:0] in_pc4,
  input  logic [1:0]  in_lsize,
  input  logic        in_lunsigned,
  input  logic [1:0]  in_byteoff,
  output logic        we3,
  output logic [4:0]  wa3,
  output logic [31:0] wd3,
  output logic        fwd_valid,
  output logic [4:0]  fwd_wa,
  output logic [31:0] fwd_data
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [31:0] retire_cnt
`endif
);

  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic [4:0]  wa;
    logic [1:0]  resultsrc;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] pc4;
    logic [1:0]  lsize;
    logic        lunsigned;
    logic [1:0]  byteoff;
  } wb_reg_t;

  wb_reg_t stage_q, stage_d;

  always_comb begin
    stage_d = stage_q;
    if (flush) begin
      stage_d.valid = 1'b0;
    end else if (!stall) begin
      stage_d.valid     = in_valid;
      stage_d.regwrite  = in_regwrite;
      stage_d.wa        = in_wa;
      stage_d.resultsrc = in_resultsrc;
      stage_d.alu       = in_alu;
      stage_d.rdata     = in_rdata;
      stage_d.pc4       = in_pc4;
      stage_d.lsize     = in_lsize;
      stage_d.lunsigned = in_lunsigned;
      stage_d.byteoff   = in_byteoff;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) stage_q <= '0;
    else     stage_q <= stage_d;
  end

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        byte_sx;
  logic        half_sx;
  logic [31:0] load_data;
  logic [31:0] result;

  always_comb begin
    byte_sel = 8'(stage_q.rdata >> {stage_q.byteoff, 3'b000});
    half_sel = stage_q.byteoff[1] ? stage_q.rdata[31:16]
                                  : stage_q.rdata[15:0];
    byte_sx  = ~stage_q.lunsigned & byte_sel[7];
    half_sx  = ~stage_q.lunsigned & half_sel[15];
    unique case (stage_q.lsize)
      2'b00:   load_data = {{24{byte_sx}}, byte_sel};
      2'b01:   load_data = {{16{half_sx}}, half_sel};
      default: load_data = stage_q.rdata;
    endcase
    unique case (stage_q.resultsrc)
      2'b01:   result = load_data;
      2'b10:   result = stage_q.pc4;
      default: result = stage_q.alu;
    endcase
  end

  // Bubbles present address/data as zero so idle cycles are quiet.
  assign we3 = stage_q.valid & stage_q.regwrite & (|stage_q.wa);
  assign wa3 = stage_q.valid ? stage_q.wa : 5'd0;
  assign wd3 = stage_q.valid ? result : 32'd0;

  assign fwd_valid = we3;
  assign fwd_wa    = wa3;
  assign fwd_data  = wd3;

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  // An instruction leaves the stage when it is replaced or flushed out.
  always_comb begin
    cnt_d = cnt_q;
    if (stage_q.valid & (~stall | flush)) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign retire_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Testbench for wb_stage: directed cases plus random traffic
// checked against a behavioural model of the writeback rules.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_regwrite = 1'b0;
  logic [4:0]  in_wa = '0;
  logic [1:0]  in_resultsrc = '0;
  logic [31:0] in_alu = '0;
  logic [31:0] in_rdata = '0;
  logic [31:0] in_pc4 = '0;
  logic [1:0]  in_lsize = '0;
  logic        in_lunsigned = 1'b0;
  logic [1:0]  in_byteoff = '0;
  logic        we3;
  logic [4:0]  wa3;
  logic [31:0] wd3;
  logic        fwd_valid;
  logic [4:0]  fwd_wa;
  logic [31:0] fwd_data;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
`endif

  wb_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_regwrite(in_regwrite),
    .in_wa(in_wa), .in_resultsrc(in_resultsrc),
    .in_alu(in_alu), .in_rdata(in_rdata), .in_pc4(in_pc4),
    .in_lsize(in_lsize), .in_lunsigned(in_lunsigned),
    .in_byteoff(in_byteoff),
    .we3(we3), .wa3(wa3), .wd3(wd3),
    .fwd_valid(fwd_valid), .fwd_wa(fwd_wa), .fwd_data(fwd_data)
`ifdef WB_RETIRE_CNT_EN
    , .retire_cnt(retire_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Model state
  bit          mv, mrw, clean;
  bit [4:0]    mwa;
  bit [31:0]   mres;
  bit [31:0]   mcnt;

  function automatic bit [31:0] ref_result(
    bit [1:0] rs, bit [31:0] alu, bit [31:0] rd, bit [31:0] pc4,
    bit [1:0] ls, bit uns, bit [1:0] off);
    bit [31:0] v;
    if (rs == 2'd2) return pc4;
    if (rs != 2'd1) return alu;
    if (ls == 2'd0) begin
      v = (rd >> (8 * off)) & 32'hFF;
      if (!uns && v >= 32'h80) v = v + 32'hFFFF_FF00;
    end else if (ls == 2'd1) begin
      v = (rd >> (16 * off[1])) & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v + 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  task automatic model_edge();
    if (rst) begin
      mv = 0; mrw = 0; mwa = 0; mres = 0; mcnt = 0; clean = 1;
    end else begin
      if (mv && (!stall || flush)) mcnt = mcnt + 1;
      if (flush) mv = 0;
      else if (!stall) begin
        mv  = in_valid;
        mrw = in_regwrite;
        mwa = in_wa;
        mres = ref_result(in_resultsrc, in_alu, in_rdata, in_pc4,
                          in_lsize, in_lunsigned, in_byteoff);
        if (in_valid) clean = 0;
      end
    end
  endtask

  task automatic compare();
    bit ew;
    ew = mv && mrw && (mwa != 0);
    chk("we3", 32'(we3), 32'(ew));
    chk("fwd_valid", 32'(fwd_valid), 32'(ew));
    if (mv) begin
      chk("wa3", 32'(wa3), 32'(mwa));
      chk("wd3", wd3, mres);
      chk("fwd_wa", 32'(fwd_wa), 32'(mwa));
      chk("fwd_data", fwd_data, mres);
    end else if (clean) begin
      chk("wa3_idle", 32'(wa3), 32'd0);
      chk("wd3_idle", wd3, 32'd0);
    end
`ifdef WB_RETIRE_CNT_EN
    chk("retire_cnt", retire_cnt, mcnt);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic set_in(bit v, bit rw, bit [4:0] wa, bit [1:0] rs,
                        bit [31:0] alu, bit [31:0] rd, bit [1:0] ls,
                        bit uns, bit [1:0] off);
    in_valid = v; in_regwrite = rw; in_wa = wa; in_resultsrc = rs;
    in_alu = alu; in_rdata = rd; in_pc4 = alu + 4;
    in_lsize = ls; in_lunsigned = uns; in_byteoff = off;
  endtask

  task automatic do_reset();
    rst = 1; stall = 0; flush = 0;
    step();
    rst = 0;
  endtask

  initial begin
    mv = 0; mrw = 0; mwa = 0; mres = 0; mcnt = 0; clean = 1;
    #2;
    set_in(1, 1, 5'd3, 0, 32'h1111_2222, 0, 0, 0, 0);
    rst = 1;
    step();
    chk("rst_we3", 32'(we3), 32'd0);
    chk("rst_wd3", wd3, 32'd0);
    rst = 0;

    // ALU write
    set_in(1, 1, 5'd5, 2'b00, 32'h1234_5678, 0, 0, 0, 0);
    step();
    chk("alu_we3", 32'(we3), 32'd1);
    chk("alu_wa3", 32'(wa3), 32'd5);
    chk("alu_wd3", wd3, 32'h1234_5678);

    // Byte loads
    set_in(1, 1, 5'd6, 2'b01, 0, 32'h80FF_7F01, 2'b00, 0, 2'd3);
    step();
    chk("lb_s", wd3, 32'hFFFF_FF80);
    set_in(1, 1, 5'd6, 2'b01, 0, 32'h80FF_7F01, 2'b00, 1, 2'd3);
    step();
    chk("lb_u", wd3, 32'h0000_0080);

    // Half loads
    set_in(1, 1, 5'd8, 2'b01, 0, 32'h8001_7FFF, 2'b01, 0, 2'd2);
    step();
    chk("lh_hi", wd3, 32'hFFFF_8001);
    set_in(1, 1, 5'd8, 2'b01, 0, 32'h8001_7FFF, 2'b01, 0, 2'd1);
    step();
    chk("lh_lo", wd3, 32'h0000_7FFF);

    // Write to r0
    set_in(1, 1, 5'd0, 2'b00, 32'hDEAD_BEEF, 0, 0, 0, 0);
    step();
    chk("r0_we3", 32'(we3), 32'd0);
    chk("r0_fwd", 32'(fwd_valid), 32'd0);

    // Stall then flush
    do_reset();
    set_in(1, 1, 5'd7, 2'b00, 32'hCAFE_0007, 0, 0, 0, 0);
    step();
    chk("st_we3_0", 32'(we3), 32'd1);
    set_in(1, 1, 5'd9, 2'b00, 32'h0BAD_0009, 0, 0, 0, 0);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("st_we3", 32'(we3), 32'd1);
      chk("st_wa3", 32'(wa3), 32'd7);
      chk("st_wd3", wd3, 32'hCAFE_0007);
    end
    flush = 1;
    step();
    chk("fl_we3", 32'(we3), 32'd0);
`ifdef WB_RETIRE_CNT_EN
    chk("fl_cnt", retire_cnt, 32'd1);
`endif
    flush = 0; stall = 0;

    // Reset mid-operation
    do_reset();
    set_in(1, 1, 5'd9, 2'b00, 32'h9999_0009, 0, 0, 0, 0);
    step();
    stall = 1;
    step();
    chk("mid_we3_pre", 32'(we3), 32'd1);
    rst = 1;
    step();
    chk("mid_we3", 32'(we3), 32'd0);
    chk("mid_wd3", wd3, 32'd0);
`ifdef WB_RETIRE_CNT_EN
    chk("mid_cnt", retire_cnt, 32'd0);
`endif
    rst = 0; stall = 0;

    // Random traffic
    for (int n = 0; n < 2000; n++) begin
      rst   = ($urandom_range(99) < 2);
      flush = ($urandom_range(99) < 10);
      stall = ($urandom_range(99) < 25);
      set_in($urandom_range(99) < 80, $urandom_range(99) < 80,
             5'($urandom), 2'($urandom), $urandom, $urandom,
             2'($urandom), 1'($urandom), 2'($urandom));
      in_pc4 = $urandom;
      step();
    end
    rst = 0; stall = 0; flush = 0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
